// File: rtl/hb_period_meter.sv
`timescale 1ns/1ps
// hb_period_meter: synchronises an asynchronous heartbeat, measures the
// interval between rising edges in prescaled time units and hands each
// interval (QF format) to the reciprocal unit over start_calc/done.
// Optional macro HB_PERIOD_AVG_EN: x_in carries the mean of the last four
// periods instead of each single period.
// state_dbg exposes the FSM state: 0=S_OFF 1=S_ARM 2=S_MEAS 3=S_WAIT.
// Handshake: start_calc is a one-cycle request issued together with a new,
// stable x_in; the reciprocal unit answers later with a one-cycle done pulse
// (invalid sampled on that same cycle). Only one request is outstanding.
module hb_period_meter #(
    parameter int W           = 32,
    parameter int F           = 16,
    parameter int SYNC_STAGES = 2,
    parameter int TICK_DIV    = 1000,
    parameter int MAX_PERIOD  = 30000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                hb_in,
    output logic                start_calc,
    input  logic                done,
    output logic signed [W-1:0] x_in,
    input  logic                invalid,
    output logic                period_valid,
    output logic                timeout,
    output logic                overrun,
    output logic                calc_err,
    output logic [1:0]          state_dbg
);
    localparam int            PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [W-1:0]  CNT_MAX  = W'(MAX_PERIOD);

    typedef enum logic [1:0] {
        S_OFF  = 2'd0,
        S_ARM  = 2'd1,
        S_MEAS = 2'd2,
        S_WAIT = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q, hist_d;
    logic                   en_q, en_d;
    logic [PW-1:0]          pre_q, pre_d;
    logic [W-1:0]           cnt_q, cnt_d;
    logic [W-1:0]           x_q, x_d;
    logic                   start_q, start_d;
    logic                   pv_q, pv_d;
    logic                   timeout_q, timeout_d;
    logic                   overrun_q, overrun_d;
    logic                   calc_err_q, calc_err_d;

    logic                   hb_edge;
    logic                   tick;
    logic                   en_rise;
    logic [W-1:0]           cnt_cur;
    logic                   take;
    logic                   issue;
    logic [W-1:0]           x_issue;

`ifdef HB_PERIOD_AVG_EN
    logic [W-1:0]           avg_q [4];
    logic [W-1:0]           avg_d [4];
    logic [2:0]             navg_q, navg_d;
    logic [W+1:0]           avg_sum;
`endif

    // Front end: synchroniser, edge detect, prescaler tick and the count
    // including this cycle's tick (so an N-unit interval measures as N).
    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], hb_in};
        hist_d  = sync_q[SYNC_STAGES-1];
        en_d    = enable;
        hb_edge = sync_q[SYNC_STAGES-1] & ~hist_q;
        en_rise = enable & ~en_q;
        tick    = (pre_q == PRE_LAST);
        cnt_cur = (tick && (cnt_q != CNT_MAX)) ? cnt_q + W'(1) : cnt_q;
    end

    // Next-state, counter control, request issue and sticky flags.
    always_comb begin
        state_d    = state_q;
        pre_d      = tick ? '0 : pre_q + PW'(1);
        cnt_d      = cnt_cur;
        x_d        = x_q;
        start_d    = 1'b0;
        pv_d       = 1'b0;
        timeout_d  = timeout_q;
        overrun_d  = overrun_q;
        calc_err_d = calc_err_q;
        take       = 1'b0;
        issue      = 1'b0;
        x_issue    = '0;
`ifdef HB_PERIOD_AVG_EN
        avg_d   = avg_q;
        navg_d  = navg_q;
        avg_sum = {2'b00, cnt_cur} + {2'b00, avg_q[0]} + {2'b00, avg_q[1]} + {2'b00, avg_q[2]};
`endif

        case (state_q)
            S_OFF: begin
                pre_d = '0;
                cnt_d = '0;
                if (enable) state_d = S_ARM;
            end
            S_ARM: begin
                pre_d = '0;
                cnt_d = '0;
                if (hb_edge) state_d = S_MEAS;
            end
            S_MEAS: begin
                // An edge with nothing counted yet is treated as a glitch.
                if (hb_edge && (cnt_cur != '0)) begin
                    take = 1'b1;
                end else if (cnt_q == CNT_MAX) begin
                    timeout_d = 1'b1;
                    state_d   = S_ARM;
                end
            end
            S_WAIT: begin
                if (cnt_q == CNT_MAX) timeout_d = 1'b1;
                if (done) begin
                    if (invalid) calc_err_d = 1'b1;
                    if (cnt_q == CNT_MAX) begin
                        state_d = S_ARM;
                    end else begin
                        // done is taken first; a coincident edge is then
                        // handled exactly as in S_MEAS.
                        state_d = S_MEAS;
                        if (hb_edge && (cnt_cur != '0)) take = 1'b1;
                    end
                end else if (hb_edge) begin
                    overrun_d = 1'b1;
                    pre_d     = '0;
                    cnt_d     = '0;
                end
            end
            default: state_d = S_OFF;
        endcase

        if (take) begin
            pre_d = '0;
            cnt_d = '0;
`ifdef HB_PERIOD_AVG_EN
            avg_d[0] = cnt_cur;
            avg_d[1] = avg_q[0];
            avg_d[2] = avg_q[1];
            avg_d[3] = avg_q[2];
            navg_d   = (navg_q == 3'd4) ? 3'd4 : navg_q + 3'd1;
            issue    = (navg_q >= 3'd3);
            // Mean of four with two extra fractional bits kept.
            x_issue  = W'(avg_sum << (F - 2));
`else
            issue    = 1'b1;
            x_issue  = cnt_cur << F;
`endif
            if (issue) begin
                x_d     = x_issue;
                start_d = 1'b1;
                pv_d    = 1'b1;
                state_d = S_WAIT;
            end
        end

        if (en_rise) begin
            timeout_d  = 1'b0;
            overrun_d  = 1'b0;
            calc_err_d = 1'b0;
        end

        if (!enable) begin
            state_d = S_OFF;
            pre_d   = '0;
            cnt_d   = '0;
            start_d = 1'b0;
            pv_d    = 1'b0;
        end

`ifdef HB_PERIOD_AVG_EN
        // History restarts whenever measurement restarts from scratch.
        if ((state_d == S_OFF) || (state_d == S_ARM)) begin
            avg_d[0] = '0;
            avg_d[1] = '0;
            avg_d[2] = '0;
            avg_d[3] = '0;
            navg_d   = 3'd0;
        end
`endif
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_OFF;
            sync_q     <= '0;
            hist_q     <= 1'b0;
            en_q       <= 1'b0;
            pre_q      <= '0;
            cnt_q      <= '0;
            x_q        <= '0;
            start_q    <= 1'b0;
            pv_q       <= 1'b0;
            timeout_q  <= 1'b0;
            overrun_q  <= 1'b0;
            calc_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            hist_q     <= hist_d;
            en_q       <= en_d;
            pre_q      <= pre_d;
            cnt_q      <= cnt_d;
            x_q        <= x_d;
            start_q    <= start_d;
            pv_q       <= pv_d;
            timeout_q  <= timeout_d;
            overrun_q  <= overrun_d;
            calc_err_q <= calc_err_d;
        end
    end

`ifdef HB_PERIOD_AVG_EN
    // Period history registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            avg_q[0] <= '0;
            avg_q[1] <= '0;
            avg_q[2] <= '0;
            avg_q[3] <= '0;
            navg_q   <= 3'd0;
        end else begin
            avg_q  <= avg_d;
            navg_q <= navg_d;
        end
    end
`endif

    assign start_calc   = start_q;
    assign period_valid = pv_q;
    assign x_in         = x_q;
    assign timeout      = timeout_q;
    assign overrun      = overrun_q;
    assign calc_err     = calc_err_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_hb_period_meter.sv
`timescale 1ns/1ps
// Testbench for hb_period_meter: TICK_DIV=4, MAX_PERIOD=20, SYNC_STAGES=2.
// Every tick() drives inputs at a falling edge and samples outputs at the
// next falling edge, i.e. after the rising edge that consumed those inputs.
// A heartbeat rise driven in tick n is seen by the FSM in tick n+2.
module tb_hb_period_meter;
    localparam int W  = 32;
    localparam int F  = 16;
    localparam int SS = 2;
    localparam int TD = 4;
    localparam int MP = 20;
    localparam logic [1:0] ST_OFF  = 2'd0;
    localparam logic [1:0] ST_ARM  = 2'd1;
    localparam logic [1:0] ST_MEAS = 2'd2;
    localparam logic [1:0] ST_WAIT = 2'd3;
    localparam int X10 = 655360;   // 10 << 16
    localparam int X6  = 393216;   // 6 << 16

    logic                clk = 1'b0;
    logic                rst;
    logic                enable;
    logic                hb_in;
    logic                done;
    logic                invalid;
    logic                start_calc;
    logic                period_valid;
    logic                timeout;
    logic                overrun;
    logic                calc_err;
    logic signed [W-1:0] x_in;
    logic [1:0]          state_dbg;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int hb_period = 0;
    int hb_phase  = 0;
    int done_delay = -1;
    int done_cnt   = 0;
    bit inv_next   = 1'b0;
    bit done_now   = 1'b0;
    int sc_pulses    = 0;
    int sc_width     = 0;
    int sc_max_width = 0;
    int sc_first     = -1;
    int sc_last      = -1;
    int pv_bad       = 0;
    bit sc_prev      = 1'b0;

    hb_period_meter #(
        .W(W), .F(F), .SYNC_STAGES(SS), .TICK_DIV(TD), .MAX_PERIOD(MP)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .hb_in(hb_in),
        .start_calc(start_calc), .done(done), .x_in(x_in), .invalid(invalid),
        .period_valid(period_valid), .timeout(timeout), .overrun(overrun),
        .calc_err(calc_err), .state_dbg(state_dbg)
    );

    // Clock and reset block.
    always #5 clk = ~clk;

    // One clock cycle: heartbeat generator, done responder, pulse monitor.
    task automatic tick();
        if (hb_period > 0) begin
            hb_in    = (hb_phase < hb_period / 2);
            hb_phase = (hb_phase + 1) % hb_period;
        end
        done    = 1'b0;
        invalid = 1'b0;
        if (done_now) begin
            done     = 1'b1;
            invalid  = inv_next;
            done_now = 1'b0;
        end else if (done_cnt > 0) begin
            done_cnt--;
            if (done_cnt == 0) begin
                done    = 1'b1;
                invalid = inv_next;
            end
        end
        @(negedge clk);
        if (start_calc === 1'b1) begin
            sc_width++;
            if (!sc_prev) begin
                sc_pulses++;
                if (sc_first < 0) sc_first = cyc;
                sc_last = cyc;
                if (done_delay > 0) done_cnt = done_delay;
            end
            if (sc_width > sc_max_width) sc_max_width = sc_width;
        end else begin
            sc_width = 0;
        end
        if (start_calc !== period_valid) pv_bad++;
        sc_prev = (start_calc === 1'b1);
        cyc++;
    endtask

    // Run until tick index i has completed.
    task automatic run_to(input int i);
        while (cyc <= i) tick();
    endtask

    // Driver: toggle enable to clear sticky flags, leave the DUT in S_ARM.
    task automatic restart();
        hb_period  = 0;
        hb_in      = 1'b0;
        done_cnt   = 0;
        done_delay = -1;
        inv_next   = 1'b0;
        done_now   = 1'b0;
        enable     = 1'b0;
        repeat (3) tick();
        enable = 1'b1;
        tick();
        sc_pulses = 0; sc_first = -1; sc_last = -1; pv_bad = 0; sc_max_width = 0;
    endtask

    task automatic start_hb(input int period, output int t0);
        t0        = cyc;
        hb_period = period;
        hb_phase  = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b1; hb_in = 1'b0;
        repeat (3) tick();
        total++; if (start_calc !== 1'b0) begin bad++; $display("FAIL reset_start_calc: got %0b want 0", start_calc); end
        total++; if (period_valid !== 1'b0) begin bad++; $display("FAIL reset_period_valid: got %0b want 0", period_valid); end
        total++; if (x_in !== 0) begin bad++; $display("FAIL reset_x_in: got %0d want 0", x_in); end
        total++; if ({timeout, overrun, calc_err} !== 3'b000) begin bad++; $display("FAIL reset_flags: got %b want 000", {timeout, overrun, calc_err}); end
        total++; if (state_dbg !== ST_OFF) begin bad++; $display("FAIL reset_state: got %0d want %0d", state_dbg, ST_OFF); end
        rst = 1'b0;
        tick();
        total++; if (state_dbg !== ST_ARM) begin bad++; $display("FAIL reset_release_state: got %0d want %0d", state_dbg, ST_ARM); end
    endtask

`ifdef HB_PERIOD_AVG_EN
    task automatic test_avg();
        int t0;
        int rises [5] = '{0, 32, 80, 112, 160};
        restart();
        done_delay = 5;
        t0 = cyc;
        for (int i = 0; i <= 165; i++) begin
            hb_in = 1'b0;
            for (int k = 0; k < 5; k++) if ((i >= rises[k]) && (i < rises[k] + 4)) hb_in = 1'b1;
            tick();
        end
        total++; if (sc_pulses !== 1) begin bad++; $display("FAIL avg_requests: got %0d want 1", sc_pulses); end
        total++; if (sc_last !== t0 + 162) begin bad++; $display("FAIL avg_issue_cycle: got %0d want %0d", sc_last, t0 + 162); end
        total++; if (x_in !== X10) begin bad++; $display("FAIL avg_x_in: got %0d want %0d", x_in, X10); end
        total++; if (state_dbg !== ST_WAIT) begin bad++; $display("FAIL avg_state_wait: got %0d want %0d", state_dbg, ST_WAIT); end
        rst = 1'b1;
        tick();
        total++; if ({start_calc, period_valid, timeout, overrun, calc_err} !== 5'b0) begin bad++; $display("FAIL avg_rst_outputs: got %b want 00000", {start_calc, period_valid, timeout, overrun, calc_err}); end
        total++; if (x_in !== 0) begin bad++; $display("FAIL avg_rst_x_in: got %0d want 0", x_in); end
        total++; if (state_dbg !== ST_OFF) begin bad++; $display("FAIL avg_rst_state: got %0d want %0d", state_dbg, ST_OFF); end
        rst = 1'b0;
        repeat (3) tick();
        total++; if (state_dbg !== ST_ARM) begin bad++; $display("FAIL avg_after_rst_state: got %0d want %0d", state_dbg, ST_ARM); end
    endtask
`else
    task automatic test_basic();
        int t0;
        restart();
        done_delay = 5;
        start_hb(40, t0);
        run_to(t0 + 45);
        total++; if (sc_pulses !== 1) begin bad++; $display("FAIL basic_requests: got %0d want 1", sc_pulses); end
        total++; if (sc_first !== t0 + 42) begin bad++; $display("FAIL basic_issue_cycle: got %0d want %0d", sc_first, t0 + 42); end
        total++; if (sc_max_width !== 1) begin bad++; $display("FAIL basic_pulse_width: got %0d want 1", sc_max_width); end
        total++; if (pv_bad !== 0) begin bad++; $display("FAIL basic_pv_align: got %0d want 0", pv_bad); end
        total++; if (x_in !== X10) begin bad++; $display("FAIL basic_x_in: got %0d want %0d", x_in, X10); end
        total++; if ({timeout, overrun, calc_err} !== 3'b000) begin bad++; $display("FAIL basic_flags: got %b want 000", {timeout, overrun, calc_err}); end
        total++; if (state_dbg !== ST_WAIT) begin bad++; $display("FAIL basic_state_wait: got %0d want %0d", state_dbg, ST_WAIT); end
        run_to(t0 + 50);
        total++; if (state_dbg !== ST_MEAS) begin bad++; $display("FAIL basic_state_meas: got %0d want %0d", state_dbg, ST_MEAS); end
    endtask

    task automatic test_period_change();
        int t0;
        restart();
        done_delay = 3;
        start_hb(24, t0);
        run_to(t0 + 55);
        total++; if (sc_pulses !== 2) begin bad++; $display("FAIL p24_requests: got %0d want 2", sc_pulses); end
        total++; if (sc_last !== t0 + 50) begin bad++; $display("FAIL p24_issue_cycle: got %0d want %0d", sc_last, t0 + 50); end
        total++; if (x_in !== X6) begin bad++; $display("FAIL p24_x_in: got %0d want %0d", x_in, X6); end
    endtask

    task automatic test_overrun();
        int t0;
        restart();
        done_delay = 60;
        start_hb(40, t0);
        run_to(t0 + 100);
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_flag: got %0b want 1", overrun); end
        total++; if (sc_pulses !== 1) begin bad++; $display("FAIL ovr_single_request: got %0d want 1", sc_pulses); end
        total++; if (state_dbg !== ST_WAIT) begin bad++; $display("FAIL ovr_state: got %0d want %0d", state_dbg, ST_WAIT); end
        run_to(t0 + 125);
        total++; if (sc_pulses !== 2) begin bad++; $display("FAIL ovr_next_request: got %0d want 2", sc_pulses); end
        total++; if (sc_last !== t0 + 122) begin bad++; $display("FAIL ovr_next_cycle: got %0d want %0d", sc_last, t0 + 122); end
        total++; if (x_in !== X10) begin bad++; $display("FAIL ovr_x_in: got %0d want %0d", x_in, X10); end
    endtask

    task automatic test_back_to_back();
        int t0;
        restart();
        done_delay = 40;   // done lands on the same cycle as the third edge
        start_hb(40, t0);
        run_to(t0 + 84);
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL b2b_overrun: got %0b want 0", overrun); end
        total++; if (sc_pulses !== 2) begin bad++; $display("FAIL b2b_requests: got %0d want 2", sc_pulses); end
        total++; if (sc_last !== t0 + 82) begin bad++; $display("FAIL b2b_issue_cycle: got %0d want %0d", sc_last, t0 + 82); end
        total++; if (x_in !== X10) begin bad++; $display("FAIL b2b_x_in: got %0d want %0d", x_in, X10); end
    endtask

    task automatic test_glitch();
        int t0;
        restart();
        t0 = cyc;
        hb_in = 1'b1; tick();
        hb_in = 1'b0; tick();
        hb_in = 1'b1; tick();
        hb_in = 1'b0;
        run_to(t0 + 30);
        total++; if (sc_pulses !== 0) begin bad++; $display("FAIL glitch_no_request: got %0d want 0", sc_pulses); end
        total++; if (state_dbg !== ST_MEAS) begin bad++; $display("FAIL glitch_state: got %0d want %0d", state_dbg, ST_MEAS); end
        run_to(t0 + 41);
        hb_in = 1'b1; tick();
        hb_in = 1'b0;
        run_to(t0 + 46);
        total++; if (sc_pulses !== 1) begin bad++; $display("FAIL glitch_next_request: got %0d want 1", sc_pulses); end
        total++; if (x_in !== X10) begin bad++; $display("FAIL glitch_x_in: got %0d want %0d", x_in, X10); end
    endtask

    task automatic test_timeout();
        int t0;
        int t1;
        restart();
        done_delay = 5;
        t0 = cyc;
        hb_in = 1'b1;
        repeat (4) tick();
        hb_in = 1'b0;
        run_to(t0 + 82);
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL to_early: got %0b want 0", timeout); end
        run_to(t0 + 83);
        total++; if (timeout !== 1'b1) begin bad++; $display("FAIL to_flag: got %0b want 1", timeout); end
        total++; if (state_dbg !== ST_ARM) begin bad++; $display("FAIL to_state: got %0d want %0d", state_dbg, ST_ARM); end
        total++; if (sc_pulses !== 0) begin bad++; $display("FAIL to_no_request: got %0d want 0", sc_pulses); end
        total++; if (x_in !== X10) begin bad++; $display("FAIL to_x_held: got %0d want %0d", x_in, X10); end
        start_hb(40, t1);
        run_to(t1 + 45);
        total++; if (sc_pulses !== 1) begin bad++; $display("FAIL to_rearm_request: got %0d want 1", sc_pulses); end
        total++; if (timeout !== 1'b1) begin bad++; $display("FAIL to_sticky: got %0b want 1", timeout); end
    endtask

    task automatic test_calc_err();
        int t0;
        restart();
        inv_next   = 1'b1;
        done_delay = 5;
        start_hb(40, t0);
        run_to(t0 + 46);
        total++; if (calc_err !== 1'b0) begin bad++; $display("FAIL cerr_before_done: got %0b want 0", calc_err); end
        run_to(t0 + 47);
        total++; if (calc_err !== 1'b1) begin bad++; $display("FAIL cerr_set: got %0b want 1", calc_err); end
        run_to(t0 + 90);
        total++; if (calc_err !== 1'b1) begin bad++; $display("FAIL cerr_sticky: got %0b want 1", calc_err); end
        hb_period = 0; hb_in = 1'b0; done_cnt = 0;
        enable = 1'b0; tick();
        total++; if (state_dbg !== ST_OFF) begin bad++; $display("FAIL cerr_disable_state: got %0d want %0d", state_dbg, ST_OFF); end
        total++; if (calc_err !== 1'b1) begin bad++; $display("FAIL cerr_held_disabled: got %0b want 1", calc_err); end
        enable = 1'b1; tick();
        total++; if (calc_err !== 1'b0) begin bad++; $display("FAIL cerr_cleared: got %0b want 0", calc_err); end
    endtask

    task automatic test_reset_mid_wait();
        int t0;
        restart();
        done_delay = -1;
        start_hb(40, t0);
        run_to(t0 + 45);
        total++; if (state_dbg !== ST_WAIT) begin bad++; $display("FAIL rstw_in_wait: got %0d want %0d", state_dbg, ST_WAIT); end
        hb_period = 0; hb_in = 1'b0;
        rst = 1'b1; tick();
        total++; if ({start_calc, period_valid, timeout, overrun, calc_err} !== 5'b0) begin bad++; $display("FAIL rstw_outputs: got %b want 00000", {start_calc, period_valid, timeout, overrun, calc_err}); end
        total++; if (x_in !== 0) begin bad++; $display("FAIL rstw_x_in: got %0d want 0", x_in); end
        total++; if (state_dbg !== ST_OFF) begin bad++; $display("FAIL rstw_state: got %0d want %0d", state_dbg, ST_OFF); end
        rst = 1'b0; tick();
        inv_next = 1'b1; done_now = 1'b1;
        tick(); tick();
        total++; if (calc_err !== 1'b0) begin bad++; $display("FAIL rstw_late_done: got %0b want 0", calc_err); end
        total++; if (state_dbg !== ST_ARM) begin bad++; $display("FAIL rstw_after_state: got %0d want %0d", state_dbg, ST_ARM); end
    endtask
`endif

    initial begin
        rst = 1'b1; enable = 1'b0; hb_in = 1'b0; done = 1'b0; invalid = 1'b0;
        test_reset();
`ifdef HB_PERIOD_AVG_EN
        test_avg();
`else
        test_basic();
        test_period_change();
        test_overrun();
        test_back_to_back();
        test_glitch();
        test_timeout();
        test_calc_err();
        test_reset_mid_wait();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
